// File: rtl/crc5_unfold2_if.sv
// ============================================================================
// Module   : crc5_unfold2_if
// Brief    : Message/remainder bundle for the 2-bit/clock CRC-5 stage.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

interface crc5_unfold2_if;
  logic [5:0] data_in;   // bit 5 enters the LFSR first
  logic [4:0] data_out;  // bit 4 is the x^4 coefficient

  modport master (
    output data_in,
    input  data_out
  );

  modport slave (
    input  data_in,
    output data_out
  );
endinterface

`default_nettype wire

// File: rtl/crc5_unfold2.sv
// ============================================================================
// Module   : crc5_unfold2
// Brief    : 2-unfolded Galois LFSR, CRC-5 (x^5+x^2+1) of a 6-bit word per 3-cycle frame.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module crc5_unfold2 (
  input  wire logic     clk,
  input  wire logic     reset,
  crc5_unfold2_if.slave bus
);

  localparam logic [1:0] C_PH_LOAD = 2'd0;
  localparam logic [1:0] C_PH_MID  = 2'd1;
  localparam logic [1:0] C_PH_LAST = 2'd2;

  // Two serial Galois steps folded into one; a is shifted in before b.
  function automatic logic [4:0] f_step2(input logic [4:0] s, input logic a, input logic b);
    logic fb1;
    logic fb2;
    fb1 = a ^ s[4];
    fb2 = b ^ s[3];
    return {s[2], s[1] ^ fb1, s[0] ^ fb2, fb1, fb2};
  endfunction

  logic [1:0] r_cnt;
  logic [4:0] r_s;
  logic [3:0] r_hold;
  logic [4:0] r_data_out;

  logic [4:0] w_base;
  logic       w_a;
  logic       w_b;
  logic [4:0] w_next;
  logic [1:0] w_cnt_next;

  // The load phase seeds from zero, so no remainder carries across frames.
  always_comb begin
    w_base     = 5'd0;
    w_a        = bus.data_in[5];
    w_b        = bus.data_in[4];
    w_cnt_next = C_PH_MID;
    case (r_cnt)
      C_PH_MID: begin
        w_base     = r_s;
        w_a        = r_hold[3];
        w_b        = r_hold[2];
        w_cnt_next = C_PH_LAST;
      end
      C_PH_LAST: begin
        w_base     = r_s;
        w_a        = r_hold[1];
        w_b        = r_hold[0];
        w_cnt_next = C_PH_LOAD;
      end
      default: begin
        w_base     = 5'd0;
        w_a        = bus.data_in[5];
        w_b        = bus.data_in[4];
        w_cnt_next = C_PH_MID;
      end
    endcase
    w_next = f_step2(w_base, w_a, w_b);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt      <= C_PH_LOAD;
      r_s        <= 5'd0;
      r_hold     <= 4'd0;
      r_data_out <= 5'd0;
    end else begin
      r_cnt <= w_cnt_next;
      r_s   <= w_next;
      if (r_cnt == C_PH_LAST) begin
        r_data_out <= w_next;
      end
      if ((r_cnt != C_PH_MID) && (r_cnt != C_PH_LAST)) begin
        r_hold <= bus.data_in[3:0];
      end
    end
  end

  assign bus.data_out = r_data_out;

endmodule

`default_nettype wire

// File: tb/tb_crc5_unfold2.sv
// ============================================================================
// Module   : tb_crc5_unfold2
// Brief    : Directed self-checking bench for crc5_unfold2.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_crc5_unfold2;

  logic clk;
  logic reset;
  int   checks;
  int   failures;

  crc5_unfold2_if bus ();

  crc5_unfold2 dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Bit-serial reference, one bit per step.
  function automatic logic [4:0] ref_crc(input logic [5:0] m);
    logic [4:0] s;
    logic       fb;
    s = 5'd0;
    for (int i = 5; i >= 0; i--) begin
      fb = m[i] ^ s[4];
      s  = {s[3], s[2], s[1] ^ fb, s[0], fb};
    end
    return s;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.data_in = 6'b111111;
    repeat (3) step();
    checks++;
    if (bus.data_out !== 5'b00000) begin
      failures++;
      $display("FAIL reset_data_out actual=%b required=00000", bus.data_out);
    end
    checks++;
    if (dut.r_cnt !== 2'd0) begin
      failures++;
      $display("FAIL reset_cnt actual=%0d required=0", dut.r_cnt);
    end
  endtask

  task automatic test_first_frame();
    @(negedge clk);
    reset = 1'b0;
    step();
    checks++;
    if (dut.r_s !== 5'b01111) begin
      failures++;
      $display("FAIL ones_s_edge1 actual=%b required=01111", dut.r_s);
    end
    step();
    checks++;
    if (dut.r_s !== 5'b10110) begin
      failures++;
      $display("FAIL ones_s_edge2 actual=%b required=10110", dut.r_s);
    end
    checks++;
    if (bus.data_out !== 5'b00000) begin
      failures++;
      $display("FAIL ones_early_out actual=%b required=00000", bus.data_out);
    end
    step();
    checks++;
    if (bus.data_out !== 5'b11101) begin
      failures++;
      $display("FAIL ones_edge3 actual=%b required=11101", bus.data_out);
    end
    for (int f = 0; f < 3; f++) begin
      for (int e = 0; e < 3; e++) begin
        step();
        checks++;
        if (bus.data_out !== 5'b11101) begin
          failures++;
          $display("FAIL ones_repeat frame=%0d edge=%0d actual=%b required=11101", f, e, bus.data_out);
        end
      end
    end
  endtask

  task automatic test_pattern_101011();
    bus.data_in = 6'b101011;
    step();
    checks++;
    if (dut.r_s !== 5'b01010) begin
      failures++;
      $display("FAIL p2b_s_edge1 actual=%b required=01010", dut.r_s);
    end
    step();
    checks++;
    if (dut.r_s !== 5'b00111) begin
      failures++;
      $display("FAIL p2b_s_edge2 actual=%b required=00111", dut.r_s);
    end
    step();
    checks++;
    if (bus.data_out !== 5'b10011) begin
      failures++;
      $display("FAIL p2b_out actual=%b required=10011", bus.data_out);
    end
  endtask

  task automatic test_vectors();
    logic [5:0] vin [3];
    logic [4:0] vexp [3];
    vin[0] = 6'b000001; vexp[0] = 5'b00101;
    vin[1] = 6'b100000; vexp[1] = 5'b10001;
    vin[2] = 6'b000000; vexp[2] = 5'b00000;
    for (int k = 0; k < 3; k++) begin
      bus.data_in = vin[k];
      repeat (3) step();
      checks++;
      if (bus.data_out !== vexp[k]) begin
        failures++;
        $display("FAIL vector in=%b actual=%b required=%b", vin[k], bus.data_out, vexp[k]);
      end
    end
  endtask

  task automatic test_midframe_change();
    bus.data_in = 6'b111111;
    step();
    bus.data_in = 6'b101011;
    step();
    step();
    checks++;
    if (bus.data_out !== 5'b11101) begin
      failures++;
      $display("FAIL change_current actual=%b required=11101", bus.data_out);
    end
    repeat (3) step();
    checks++;
    if (bus.data_out !== 5'b10011) begin
      failures++;
      $display("FAIL change_next actual=%b required=10011", bus.data_out);
    end
  endtask

  task automatic test_async_reset();
    bus.data_in = 6'b111111;
    repeat (3) step();
    checks++;
    if (bus.data_out !== 5'b11101) begin
      failures++;
      $display("FAIL areset_prev actual=%b required=11101", bus.data_out);
    end
    step();
    reset = 1'b1;
    #1;
    checks++;
    if (bus.data_out !== 5'b00000) begin
      failures++;
      $display("FAIL areset_clear actual=%b required=00000", bus.data_out);
    end
    checks++;
    if (dut.r_cnt !== 2'd0) begin
      failures++;
      $display("FAIL areset_cnt actual=%0d required=0", dut.r_cnt);
    end
    @(negedge clk);
    reset = 1'b0;
    bus.data_in = 6'b101011;
    step();
    step();
    checks++;
    if (bus.data_out !== 5'b00000) begin
      failures++;
      $display("FAIL areset_wait actual=%b required=00000", bus.data_out);
    end
    step();
    checks++;
    if (bus.data_out !== 5'b10011) begin
      failures++;
      $display("FAIL areset_frame actual=%b required=10011", bus.data_out);
    end
  endtask

  task automatic test_exhaustive();
    logic [5:0] m;
    logic [4:0] exp_crc;
    for (int v = 0; v < 64; v++) begin
      m = 6'(v);
      exp_crc = ref_crc(m);
      bus.data_in = m;
      repeat (3) step();
      checks++;
      if (bus.data_out !== exp_crc) begin
        failures++;
        $display("FAIL sweep in=%b actual=%b required=%b", m, bus.data_out, exp_crc);
      end
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    reset    = 1'b1;
    bus.data_in = 6'd0;
    test_reset();
    test_first_frame();
    test_pattern_101011();
    test_vectors();
    test_midframe_change();
    test_async_reset();
    test_exhaustive();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/crc5_unfold2.md
Name: crc5_unfold2

Overview:
- 2-unfolded (2 bits/clock) Galois LFSR computing the CRC-5 remainder of a 6-bit message.
- Polynomial G(x) = x^5 + x^2 + 1.
- Each 6-bit word is processed MSB-first over a fixed 3-cycle frame. The 5-bit remainder of M(x)·x^5 mod G(x) is registered on the output once per frame.
- Serves as the unfolded (J=2) CRC datapath stage in the CRC/LFSR architecture set.

Parameters:
- None. Polynomial, message width (6), CRC width (5) and unfolding factor (2) are fixed.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- data_in  input  6  message word; bit 5 is the first bit shifted in.
- data_out  output  5  registered CRC remainder; bit 4 is the x^4 coefficient.

Behaviour:
- One clock; reset is asynchronous and active-high.
- Registers:
  - cnt: 2-bit frame counter, 0→1→2→0.
  - s[4:0]: LFSR state.
  - hold[3:0]: latched low message bits.
  - data_out[4:0].
- Reset (async assert, any time including mid-frame): cnt=0, s=0, hold=0, data_out=0. A partial frame is discarded.
- Unfolded next-state function f(s,a,b), where a is the earlier bit and b the later bit:
  - fb1 = a ^ s4; fb2 = b ^ s3.
  - next = {s2, s1^fb1, s0^fb2, fb1, fb2}.
  - This equals two serial steps of: fb = bit ^ s4; s = {s3, s2, s1^fb, s0, fb}.
- Per rising edge, when reset is low:
  - cnt=0: s ← f(0, data_in[5], data_in[4]). The previous state is ignored, so every frame starts from zero. hold ← data_in[3:0]; cnt ← 1.
  - cnt=1: s ← f(s, hold[3], hold[2]); cnt ← 2.
  - cnt=2: data_out ← f(s, hold[1], hold[0]); s ← that same value; cnt ← 0.
  - cnt=3 (unreachable): treat as cnt=0.
- data_in is sampled only at the cnt=0 edge. Changes at other edges do not affect the current frame.
- Latency: data_out updates on the 3rd rising edge after reset release, then every 3 edges. It holds its value between updates.
- For a constant data_in, data_out is identical every frame (no carry-over between frames).
- No padding or augmentation cycles. The Galois feed-in form yields M(x)·x^5 mod G directly after 6 bits.
- Zero message gives a zero CRC. No inversion, no reflection, no initial seed.
- Outputs are driven only from registers, so there is no combinational path from data_in to data_out.

Test Plan:
- Reset held with data_in=6'b111111 → data_out=00000, cnt=0. Release reset → after edge 1 s=01111, after edge 2 s=10110, after edge 3 data_out=5'b11101. data_out stays 11101 on every subsequent frame.
- data_in=6'b101011 → intermediate s=01010 then 00111; data_out=5'b10011 after 3 edges.
- data_in=6'b000001 → data_out=5'b00101 (x^5 mod G). data_in=6'b100000 → data_out=5'b10001 (x^10 mod G = x^4+1). data_in=0 → data_out=00000.
- Change data_in from 111111 to 101011 at the cnt=1 edge → current frame still yields 11101; the next frame yields 10011.
- Assert reset mid-frame (cnt=1) after a previous result of 11101 → data_out clears to 00000 immediately (asynchronous). After release, a full 3-edge frame is required before a new result appears.
- Compare against a serial 1-bit reference LFSR over all 64 data_in values → exact match each frame.
